gf233_reduce_seq: RTL and testbench

//  Digit-serial reducer: consumes a 465-bit GF(2)[x] product (output of karatsuba_recurse/ks233)
//  and returns its residue mod f(x)=x^233+x^74+1 as a 233-bit field element. Registered

---
 rtl/gf233_reduce_seq_pkg.sv | 12 +
 rtl/gf233_reduce_seq_if.sv | 12 +
 rtl/gf233_reduce_seq_fold_digit.sv | 20 ++
 rtl/gf233_reduce_seq.sv | 53 +++++
 tb/tb_gf233_reduce_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/gf233_reduce_seq_pkg.sv
// gf233_reduce_seq_pkg: field constants, FSM state type and fold-count helper for the GF(2^233) reducer
package gf233_reduce_seq_pkg;
  localparam int M = 233;
  localparam int PROD_W = 465;
  localparam int TAP = 74;
  localparam int FOLD_SHIFT_HI = 233;
  localparam int FOLD_SHIFT_LO = 159;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} red_state_t;
  function automatic int nstep(int digit);
    return (M - 1) / digit;
  endfunction
endpackage

// File: rtl/gf233_reduce_seq_if.sv
// gf233_reduce_seq_if: product-in / residue-out valid-ready bundle
interface gf233_reduce_seq_if;
  import gf233_reduce_seq_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] in_prod;
  logic out_valid;
  logic out_ready;
  logic [M-1:0] out_res;
  modport master (output in_valid, in_prod, out_ready, input in_ready, out_valid, out_res);
  modport slave (input in_valid, in_prod, out_ready, output in_ready, out_valid, out_res);
endinterface

// File: rtl/gf233_reduce_seq_fold_digit.sv
// gf233_fold_digit: folds the DIGIT-wide slice at position cnt back below it using x^233 = x^74 + 1
module gf233_fold_digit
  import gf233_reduce_seq_pkg::*;
#(
  parameter int DIGIT = 29,
  parameter int CW = $clog2(nstep(DIGIT) + 1)
) (
  input  logic [PROD_W-1:0] work,
  input  logic [CW-1:0]     cnt,
  output logic [PROD_W-1:0] next
);
  logic [9:0] lo;
  logic [DIGIT-1:0] d;
  logic [PROD_W-1:0] dw;
  assign lo = 10'(PROD_W - DIGIT) - 10'(cnt) * 10'(DIGIT);
  assign d = DIGIT'(work >> lo);
  assign dw = {{(PROD_W - DIGIT){1'b0}}, d};
  // clearing the digit and adding its two images below it; images never reach the digit itself
  assign next = work ^ (dw << lo) ^ (dw << (lo - 10'(FOLD_SHIFT_HI))) ^ (dw << (lo - 10'(FOLD_SHIFT_LO)));
endmodule

// File: rtl/gf233_reduce_seq.sv
// gf233_reduce_seq: digit-serial reduction of a 465-bit product modulo x^233 + x^74 + 1
module gf233_reduce_seq
  import gf233_reduce_seq_pkg::*;
#(
  parameter int DIGIT = 29
) (
  input  logic clk,
  input  logic rst_n,
  gf233_reduce_seq_if.slave bus,
  output logic busy
);
  localparam int NSTEP = nstep(DIGIT);
  localparam int CW = $clog2(NSTEP + 1);
  if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 29 && DIGIT != 58 && DIGIT != 116) begin : g_bad_digit
    $error("gf233_reduce_seq: illegal DIGIT %0d", DIGIT);
  end
  red_state_t state;
  logic [PROD_W-1:0] work, work_next;
  logic [CW-1:0] cnt;
  logic [M-1:0] res;
  logic res_valid;
  gf233_fold_digit #(.DIGIT(DIGIT), .CW(CW)) u_fold (.work(work), .cnt(cnt), .next(work_next));
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = res_valid;
  assign bus.out_res = res;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      cnt <= '0;
      res <= '0;
      res_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        work <= bus.in_prod;
        cnt <= '0;
        state <= BUSY;
      end
    end else if (state == BUSY) begin
      work <= work_next;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(NSTEP - 1)) begin
        state <= DONE;
        res <= work_next[M-1:0];
        res_valid <= 1'b1;
      end
    end else if (bus.out_ready) begin
      state <= IDLE;
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gf233_reduce_seq.sv
// tb_gf233_reduce_seq: random and directed products checked against a bitwise polynomial-division model
module tb_gf233_reduce_seq;
  localparam int DIGIT = 29;
  localparam int NSTEP = 232 / DIGIT;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int pass_cnt = 0;
  int total_cnt = 0;
  bit rnd = 1'b0;
  bit hold = 1'b0;
  logic [232:0] held;
  logic [232:0] q[$];
  gf233_reduce_seq_if bus ();
  gf233_reduce_seq #(.DIGIT(DIGIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  always #5 clk = ~clk;

  function automatic logic [232:0] reduce(input logic [464:0] p);
    logic [464:0] r = p;
    for (int i = 464; i >= 233; i--)
      if (r[i]) begin
        r[i] = 1'b0;
        r[i-159] = ~r[i-159];
        r[i-233] = ~r[i-233];
      end
    return r[232:0];
  endfunction

  function automatic logic [464:0] clmul(input logic [232:0] a, input logic [232:0] b);
    logic [464:0] r = '0;
    for (int i = 0; i < 233; i++)
      if (b[i]) r = r ^ ({232'b0, a} << i);
    return r;
  endfunction

  function automatic logic [232:0] rnd233();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[232:0];
  endfunction

  task automatic chk(input string name, input logic [464:0] act, input logic [464:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) q.push_back(reduce(bus.in_prod));
      chk("busy_vs_in_ready", busy, !bus.in_ready);
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("out_res", bus.out_res, q[0]);
        if (hold) chk("out_res_stable", bus.out_res, held);
        if (bus.out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = bus.out_res;
        end
      end else begin
        if (hold) chk("out_valid_held", 0, 1);
        hold = 1'b0;
      end
    end
  end

  always @(posedge clk)
    if (rnd) begin
      #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end

  task automatic send(input logic [464:0] p);
    bit done = 1'b0;
    bus.in_prod = p;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_dir(input string name, input logic [464:0] p, input logic [232:0] exp);
    int n = 0;
    bus.out_ready = 1'b1;
    send(p);
    while (!bus.out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, n, NSTEP);
    chk(name, bus.out_res, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [464:0] p;
    logic [232:0] e;
    int n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_prod = '0;
    bus.out_ready = 1'b1;
    #22;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_res", bus.out_res, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    p = '0; p[233] = 1'b1;
    e = '0; e[74] = 1'b1; e[0] = 1'b1;
    chk("model_x233", reduce(p), e);
    @(posedge clk);
    #1;
    run_dir("x233", p, e);
    p = '0; p[464] = 1'b1;
    e = '0; e[231] = 1'b1; e[146] = 1'b1; e[72] = 1'b1;
    chk("model_x464", reduce(p), e);
    run_dir("x464", p, e);
    p = 465'h1F;
    run_dir("small", p, 233'h1F);
    run_dir("zero", '0, '0);
    // backpressure: result must hold and a waiting product must not be taken
    bus.out_ready = 1'b0;
    p = '0; p[233] = 1'b1;
    send(p);
    n = 0;
    while (!bus.out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_prod = {465{1'b1}};
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_res", bus.out_res, (233'b1 << 74) | 233'b1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", bus.out_valid, 0);
    // abort during the third fold cycle
    p = {232'b0, rnd233()} << 200;
    send(p);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_res", bus.out_res, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p = '0; p[464] = 1'b1;
    run_dir("after_abort", p, (233'b1 << 231) | (233'b1 << 146) | (233'b1 << 72));
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(clmul(rnd233(), rnd233()));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
